// File: rtl/single_port_ram.sv
// -----------------------------------------------------------------------------
// single_port_ram
//   64 x 8 synchronous single-port RAM with a registered read port.
//   One shared address serves both the write and the read path. A write cycle
//   also drives the written word onto the output register (write-through), so
//   the output always reflects the addressed word one cycle after the edge.
//
//   Parameters:
//     DATA_WIDTH : word width in bits (data, out)
//     ADDR_WIDTH : address width in bits
//     DEPTH      : number of words, must equal 2**ADDR_WIDTH
//
//   Ports:
//     clk  : single clock, all state updates on the rising edge
//     rst  : asynchronous active-high reset (clears out; see macro below)
//     data : write data
//     addr : shared read/write address
//     we   : write enable, 1 = write, 0 = read
//     out  : registered read data
//
//   Build option:
//     SPRAM_CLEAR_ON_RESET_EN
//       defined   : rst also asynchronously clears every word to 0 (flop array).
//       undefined : rst only clears out; the array is a plain inferred RAM and
//                   keeps its contents across reset.
// -----------------------------------------------------------------------------
module single_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] out
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_out;
    logic                  w_wr_en;

    assign w_wr_en = we & ~rst;

`ifdef SPRAM_CLEAR_ON_RESET_EN
    // Resettable storage: every word is cleared while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i[ADDR_WIDTH-1:0]] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addr] <= data;
        end
    end
`else
    // No reset on the array so it maps onto a RAM macro; rst is only used
    // to block writes, which keeps the contents intact across reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[addr] <= data;
        end
    end
`endif

    // Output register: write-through on write cycles, array read otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (we) begin
            r_out <= data;
        end else begin
            r_out <= r_mem[addr];
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_single_port_ram.sv
module tb_single_port_ram;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
`ifdef SPRAM_CLEAR_ON_RESET_EN
    localparam bit CLEAR_ON_RST = 1'b1;
`else
    localparam bit CLEAR_ON_RST = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] out;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain array of words plus "has a defined value" flags.
    logic [DW-1:0] ref_mem   [DEPTH];
    bit            ref_known [DEPTH];

    single_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .data(data),
        .addr(addr),
        .we  (we),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, take the edge, then compare 1 time unit later.
    task automatic cycle(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        logic [DW-1:0] exp;
        bit            exp_known;
        we   = w;
        addr = a;
        data = d;
        @(posedge clk);
        #1;
        exp_known = 1'b1;
        if (rst) begin
            exp = '0;
        end else if (w) begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
            exp          = d;
        end else begin
            exp       = ref_mem[a];
            exp_known = ref_known[a];
        end
        if (exp_known) check(tag, out, exp);
    endtask

    // Assert rst between edges, optionally hold it across one edge with a
    // write attempt, then release between edges.
    task automatic reset_pulse(input string tag, input bit hold_edge);
        rst = 1'b1;
        #1;
        check({tag, "_async"}, out, '0);
        for (int i = 0; i < DEPTH; i++) begin
            if (CLEAR_ON_RST) begin
                ref_mem[i]   = '0;
                ref_known[i] = 1'b1;
            end
        end
        if (hold_edge) begin
            cycle({tag, "_hold"}, 1'b1, AW'($urandom_range(DEPTH - 1)), DW'($urandom));
        end
        rst = 1'b0;
        #1;
        check({tag, "_release"}, out, '0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        rst  = 1'b1;
        we   = 1'b0;
        addr = '0;
        data = '0;
        #1;
        check("reset_t0", out, 8'h00);
        cycle("reset_edge", 1'b1, 6'd5, 8'h77);  // write blocked during reset
        cycle("reset_edge2", 1'b0, 6'd5, 8'h00);
        if (CLEAR_ON_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i]   = '0;
                ref_known[i] = 1'b1;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        check("reset_release", out, 8'h00);
        if (CLEAR_ON_RST) cycle("blocked_write_rd5", 1'b0, 6'd5, 8'h00);

        // Consecutive writes with write-through
        cycle("wr_a1", 1'b1, 6'd1, 8'ha1);
        cycle("wr_b2", 1'b1, 6'd2, 8'hb2);
        cycle("wr_c3", 1'b1, 6'd3, 8'hc3);
        // Reads
        cycle("rd_2", 1'b0, 6'd2, 8'h00);
        cycle("rd_1", 1'b0, 6'd1, 8'h00);
        // Writes then read-after-write on the next edge
        cycle("wr_df", 1'b1, 6'd50, 8'hdf);
        cycle("wr_ee", 1'b1, 6'd51, 8'hee);
        cycle("rd_50", 1'b0, 6'd50, 8'h00);
        cycle("rd_51", 1'b0, 6'd51, 8'h00);
        cycle("rd_3", 1'b0, 6'd3, 8'h00);
        cycle("raw_wr", 1'b1, 6'd9, 8'h3c);
        cycle("raw_rd", 1'b0, 6'd9, 8'h00);
        // Mid-stream reset: contents survive or clear depending on build
        reset_pulse("rst_mid", 1'b1);
        cycle("rd_50_after_rst", 1'b0, 6'd50, 8'h00);
        check("rd_50_value", out, CLEAR_ON_RST ? 8'h00 : 8'hdf);
        // Boundary addresses
        cycle("wr_0", 1'b1, 6'd0, 8'h11);
        cycle("wr_ff63", 1'b1, 6'd63, 8'hff);
        cycle("rd_0", 1'b0, 6'd0, 8'h00);
        cycle("rd_63", 1'b0, 6'd63, 8'h00);
        check("rd_63_value", out, 8'hff);
        cycle("rd_0_again", 1'b0, 6'd0, 8'h00);

        // Randomized mix with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(59) == 0) begin
                reset_pulse("rnd_rst", bit'($urandom_range(1)));
            end else begin
                cycle("rnd", bit'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)),
                      DW'($urandom));
            end
        end
        // Read back every address
        for (int i = 0; i < DEPTH; i++) begin
            cycle("sweep", 1'b0, AW'(i), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
